// File: rtl/fetch_mem_responder.sv
// Instruction-side fetch responder: one request in flight, fixed LATENCY to a
// one-cycle VALID pulse, preloadable store, flush on redirect.
module fetch_mem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic                     MEM_RDEN1,
  input  logic [31:0]              MEM_ADDR1,
  input  logic                     FLUSH,
  input  logic                     LOAD_EN,
  input  logic [$clog2(DEPTH)-1:0] LOAD_ADDR,
  input  logic [31:0]              LOAD_DATA,
  output logic [31:0]              MEM_DOUT1,
  output logic                     MEM_VALID1,
  output logic                     RAW_MEM_BUSY_1,
  output logic                     MEM_ERR1
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic          err_q, err_d;
  logic          ok_q, ok_d;
  logic [31:0]   rd_word_q;
  logic [31:0]   mem [DEPTH];

  logic          accept;
  logic          enter_done;
  logic [31:0]   rd_addr;
  logic [AW-1:0] rd_idx;
  logic          rd_err;

  function automatic logic addr_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> (AW + 2)) != 32'd0);
  endfunction

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
      ok_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      ok_q    <= ok_d;
    end
  end

  // Store has no reset; the read word is masked by ok_q so DOUT reads 0 until a good response.
  always_ff @(posedge CLK) begin
    if (LOAD_EN) mem[LOAD_ADDR] <= LOAD_DATA;
    if (enter_done) rd_word_q <= mem[rd_idx];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    accept  = MEM_RDEN1 && ((state_q != WAIT) || FLUSH);
    if (accept) begin
      addr_d  = MEM_ADDR1;
      cnt_d   = CNT_INIT;
      state_d = (LATENCY == 1) ? DONE : WAIT;
    end else begin
      case (state_q)
        WAIT: begin
          if (FLUSH)            state_d = IDLE;
          else if (cnt_q == '0) state_d = DONE;
          else                  cnt_d   = cnt_q - 4'd1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // With LATENCY=1 the accepting edge is also the DONE-entry edge, so read the live address.
  always_comb begin
    enter_done = (state_d == DONE);
    rd_addr    = accept ? MEM_ADDR1 : addr_q;
    rd_idx     = rd_addr[AW+1:2];
    rd_err     = addr_err(rd_addr);
    err_d      = enter_done ? rd_err  : err_q;
    ok_d       = enter_done ? !rd_err : ok_q;
  end

  always_comb begin
    MEM_VALID1     = (state_q == DONE) && !FLUSH;
    RAW_MEM_BUSY_1 = (state_q == WAIT);
    MEM_ERR1       = err_q;
    MEM_DOUT1      = ok_q ? rd_word_q : 32'd0;
  end

endmodule

// File: tb/tb_fetch_mem_responder.sv
// Bench for fetch_mem_responder: four instances (latency 2/3/4/1, one with a
// 16-word store) driven by shared stimulus and checked against a request model.
module tb_fetch_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rden = 1'b0;
  logic [31:0] addr = '0;
  logic        flush = 1'b0;
  logic        lden = 1'b0;
  logic [9:0]  laddr = '0;
  logic [31:0] ldata = '0;

  logic [31:0] dout [4];
  logic        vld  [4];
  logic        busy [4];
  logic        err  [4];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  fetch_mem_responder #(.DEPTH(1024), .LATENCY(2)) u0 (
    .CLK(clk), .RESET_N(rst_n), .MEM_RDEN1(rden), .MEM_ADDR1(addr), .FLUSH(flush),
    .LOAD_EN(lden), .LOAD_ADDR(laddr), .LOAD_DATA(ldata),
    .MEM_DOUT1(dout[0]), .MEM_VALID1(vld[0]), .RAW_MEM_BUSY_1(busy[0]), .MEM_ERR1(err[0]));
  fetch_mem_responder #(.DEPTH(1024), .LATENCY(3)) u1 (
    .CLK(clk), .RESET_N(rst_n), .MEM_RDEN1(rden), .MEM_ADDR1(addr), .FLUSH(flush),
    .LOAD_EN(lden), .LOAD_ADDR(laddr), .LOAD_DATA(ldata),
    .MEM_DOUT1(dout[1]), .MEM_VALID1(vld[1]), .RAW_MEM_BUSY_1(busy[1]), .MEM_ERR1(err[1]));
  fetch_mem_responder #(.DEPTH(1024), .LATENCY(4)) u2 (
    .CLK(clk), .RESET_N(rst_n), .MEM_RDEN1(rden), .MEM_ADDR1(addr), .FLUSH(flush),
    .LOAD_EN(lden), .LOAD_ADDR(laddr), .LOAD_DATA(ldata),
    .MEM_DOUT1(dout[2]), .MEM_VALID1(vld[2]), .RAW_MEM_BUSY_1(busy[2]), .MEM_ERR1(err[2]));
  fetch_mem_responder #(.DEPTH(16), .LATENCY(1)) u3 (
    .CLK(clk), .RESET_N(rst_n), .MEM_RDEN1(rden), .MEM_ADDR1(addr), .FLUSH(flush),
    .LOAD_EN(lden), .LOAD_ADDR(laddr[3:0]), .LOAD_DATA(ldata),
    .MEM_DOUT1(dout[3]), .MEM_VALID1(vld[3]), .RAW_MEM_BUSY_1(busy[3]), .MEM_ERR1(err[3]));

  // Reference model: each instance holds at most one outstanding request with a
  // number of edges left until its response is due.
  logic [31:0] mdl_mem [4][1024];
  bit          m_wait [4];
  int          m_left [4];
  logic [31:0] m_addr [4];
  bit          m_resp [4];
  logic [31:0] m_dout [4];
  bit          m_err  [4];

  function automatic int lat_of(input int i);
    case (i)
      0: return 2;
      1: return 3;
      2: return 4;
      default: return 1;
    endcase
  endfunction

  function automatic int dep_of(input int i);
    return (i == 3) ? 16 : 1024;
  endfunction

  function automatic int aw_of(input int i);
    return (i == 3) ? 4 : 10;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic respond(input int i);
    logic [31:0] a;
    bit e;
    a = m_addr[i];
    e = (a[1:0] != 2'b00) || ((a >> (aw_of(i) + 2)) != 32'd0);
    m_err[i]  = e;
    m_dout[i] = e ? 32'd0 : mdl_mem[i][(a >> 2) % dep_of(i)];
    m_resp[i] = 1'b1;
  endtask

  task automatic model_step();
    for (int i = 0; i < 4; i++) begin
      if (!rst_n) begin
        m_wait[i] = 1'b0;
        m_resp[i] = 1'b0;
        m_dout[i] = 32'd0;
        m_err[i]  = 1'b0;
      end else begin
        m_resp[i] = 1'b0;
        if (rden && (!m_wait[i] || flush)) begin
          m_addr[i] = addr;
          m_wait[i] = 1'b0;
          if (lat_of(i) == 1) respond(i);
          else begin
            m_wait[i] = 1'b1;
            m_left[i] = lat_of(i) - 1;
          end
        end else if (m_wait[i] && flush) begin
          m_wait[i] = 1'b0;
        end else if (m_wait[i]) begin
          m_left[i]--;
          if (m_left[i] == 0) begin
            m_wait[i] = 1'b0;
            respond(i);
          end
        end
      end
      if (lden) mdl_mem[i][int'(laddr) % dep_of(i)] = ldata;
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("valid%0d", i), {31'd0, vld[i]},  {31'd0, m_resp[i] && !flush});
      chk($sformatf("busy%0d", i),  {31'd0, busy[i]}, {31'd0, m_wait[i]});
      chk($sformatf("err%0d", i),   {31'd0, err[i]},  {31'd0, m_err[i]});
      chk($sformatf("dout%0d", i),  dout[i], m_dout[i]);
    end
  endtask

  // One clock: advance the model over the edge, drive the next inputs, compare.
  task automatic cycle(input bit r, input bit rd, input logic [31:0] a, input bit fl,
                       input bit le, input logic [9:0] la, input logic [31:0] ld);
    @(posedge clk);
    model_step();
    #1;
    rst_n = r; rden = rd; addr = a; flush = fl; lden = le; laddr = la; ldata = ld;
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0);
  endtask

  task automatic fetch(input logic [31:0] a);
    cycle(1'b1, 1'b1, a, 1'b0, 1'b0, 10'd0, 32'd0);
  endtask

  initial begin
    logic [31:0] old5;
    logic [31:0] ra;
    int r;

    for (int i = 0; i < 4; i++) begin
      m_wait[i] = 0; m_left[i] = 0; m_addr[i] = '0;
      m_resp[i] = 0; m_dout[i] = '0; m_err[i] = 0;
    end

    // Reset held with a request pending, then release with RDEN low.
    cycle(1'b0, 1'b1, 32'h0000000C, 1'b0, 1'b0, 10'd0, 32'd0);
    cycle(1'b0, 1'b1, 32'h0000000C, 1'b0, 1'b0, 10'd0, 32'd0);
    idle(3);

    for (int k = 0; k < 1024; k++)
      cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 10'(k), (k == 3) ? 32'h00500093 : $urandom);
    idle(1);

    // Basic fetch on the latency-2 instance.
    fetch(32'h0000000C);
    idle(1);
    chk("basic_busy", {31'd0, busy[0]}, 32'd1);
    idle(1);
    chk("basic_valid", {31'd0, vld[0]}, 32'd1);
    chk("basic_dout", dout[0], 32'h00500093);
    chk("basic_err", {31'd0, err[0]}, 32'd0);
    idle(4);

    // Back-to-back on the latency-3 instance, with ignored requests while busy.
    fetch(32'h0);
    fetch(32'h100);
    fetch(32'h4);
    fetch(32'h4);
    fetch(32'h200);
    fetch(32'h8);
    idle(5);

    // Error responses, then a clean fetch clears ERR.
    fetch(32'h00000006);
    idle(5);
    chk("misalign_err", {31'd0, err[0]}, 32'd1);
    chk("misalign_dout", dout[0], 32'd0);
    fetch(32'h00001000);
    idle(5);
    chk("range_err", {31'd0, err[1]}, 32'd1);
    chk("range_dout", dout[1], 32'd0);
    fetch(32'h00000000);
    idle(5);
    chk("clear_err", {31'd0, err[2]}, 32'd0);

    // Flush in the second WAIT cycle of the latency-4 instance, then flush plus redirect.
    fetch(32'h10);
    idle(1);
    cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 10'd0, 32'd0);
    idle(5);
    fetch(32'h10);
    idle(1);
    cycle(1'b1, 1'b1, 32'h20, 1'b1, 1'b0, 10'd0, 32'd0);
    idle(6);
    chk("redirect_dout", dout[2], mdl_mem[2][8]);

    // Load on the DONE-entry edge of the latency-2 instance returns the old word.
    old5 = mdl_mem[0][5];
    fetch(32'h14);
    cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 10'd5, ~old5);
    idle(1);
    chk("race_old", dout[0], old5);
    idle(4);
    fetch(32'h14);
    idle(5);
    chk("race_new", dout[0], ~old5);

    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2: ra = 32'($urandom_range(0, 15)) << 2;
        3, 4, 5, 6: ra = 32'($urandom_range(0, 1023)) << 2;
        7: ra = (32'($urandom_range(0, 1023)) << 2) | 32'($urandom_range(1, 3));
        8: ra = 32'h1 << $urandom_range(12, 31);
        default: ra = $urandom;
      endcase
      cycle($urandom_range(0, 99) != 0, $urandom_range(0, 99) < 40, ra,
            $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 10,
            10'($urandom_range(0, 1023)), $urandom);
    end
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
